// File: rtl/ex_mem_stage_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_stage_reg
//   EX->MEM pipeline register with a valid/ready handshake and a two-entry
//   skid buffer (main + skid). Carries PC, ALU result, Rm value, destination
//   index and the WB/MEM control bits. Entries leave in strict FIFO order.
//   The control outputs are gated by out_valid, so a bubble can never write
//   the register file or memory.
//
// Optional feature (macro EX_MEM_STAGE_STATS_EN):
//   Adds stall_cnt (cycles with out_valid & ~out_ready) and flush_cnt (valid
//   entries discarded by flush). Both clear on RST and wrap at 2^32.
//
// Ports
//   CLK, RST            clock (rising edge), synchronous active-high reset
//   flush               drop every held entry and any input taken this cycle
//   in_valid/in_ready   upstream handshake (in_ready depends on state only)
//   PC_In .. MEM_W_EN_In  EX result bundle
//   out_valid/out_ready downstream handshake
//   PC_Out .. MEM_W_EN_Out registered bundle (control bits gated by out_valid)
//   stall_cnt, flush_cnt  statistics (only with EX_MEM_STAGE_STATS_EN)
// ---------------------------------------------------------------------------
module ex_mem_stage_reg #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int DEST_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   PC_In,
  input  logic [DATA_W-1:0] ALU_Res_In,
  input  logic [DATA_W-1:0] Val_Rm_In,
  input  logic [DEST_W-1:0] Dest_In,
  input  logic              WB_EN_In,
  input  logic              MEM_R_EN_In,
  input  logic              MEM_W_EN_In,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   PC_Out,
  output logic [DATA_W-1:0] ALU_Res_Out,
  output logic [DATA_W-1:0] Val_Rm_Out,
  output logic [DEST_W-1:0] Dest_Out,
  output logic              WB_EN_Out,
  output logic              MEM_R_EN_Out,
  output logic              MEM_W_EN_Out
`ifdef EX_MEM_STAGE_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] val_rm;
    logic [DEST_W-1:0] dest;
    logic              wb_en;
    logic              mem_r_en;
    logic              mem_w_en;
  } bundle_t;

  bundle_t in_bundle;
  bundle_t main_q;
  bundle_t skid_q;
  logic    main_valid;
  logic    skid_valid;
  logic    accept;
  logic    drain;

  assign in_bundle = '{pc:       PC_In,
                       alu_res:  ALU_Res_In,
                       val_rm:   Val_Rm_In,
                       dest:     Dest_In,
                       wb_en:    WB_EN_In,
                       mem_r_en: MEM_R_EN_In,
                       mem_w_en: MEM_W_EN_In};

  // Ready comes straight from a flop so no combinational path runs from
  // out_ready back to in_ready.
  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign drain    = main_valid & out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: the data registers are reset too (not only the valids) because
      // the outputs must read as zero straight out of reset.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      // Flush wins over accept and reload; data contents become don't-care.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (!main_valid || drain) begin
        // Main frees up this edge: the older skid entry has priority over
        // new input so ordering stays FIFO. When skid is full, in_ready is
        // low, so no accept can collide with the skid move.
        if (skid_valid) begin
          main_q     <= skid_q;
          skid_valid <= 1'b0;
        end else if (accept) begin
          main_q     <= in_bundle;
          main_valid <= 1'b1;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (accept) begin
        // Main is stalled: park the new bundle in the skid entry.
        skid_q     <= in_bundle;
        skid_valid <= 1'b1;
      end
    end
  end

`ifdef EX_MEM_STAGE_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (main_valid && !out_ready) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (flush) begin
        flush_cnt <= flush_cnt + 32'(main_valid) + 32'(skid_valid);
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

  assign out_valid    = main_valid;
  assign PC_Out       = main_q.pc;
  assign ALU_Res_Out  = main_q.alu_res;
  assign Val_Rm_Out   = main_q.val_rm;
  assign Dest_Out     = main_q.dest;
  assign WB_EN_Out    = main_q.wb_en    & main_valid;
  assign MEM_R_EN_Out = main_q.mem_r_en & main_valid;
  assign MEM_W_EN_Out = main_q.mem_w_en & main_valid;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_stage_reg
//   Directed vectors drive the EX side; every bundle the stage takes is
//   pushed into a scoreboard queue. A monitor on the falling edge pops and
//   compares whenever the MEM side completes a transfer, and checks that the
//   control outputs read zero whenever out_valid is low.
// ---------------------------------------------------------------------------
module tb_ex_mem_stage_reg;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rm;
    logic [3:0]  dest;
    logic        wb;
    logic        mr;
    logic        mw;
  } item_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] PC_In;
  logic [31:0] ALU_Res_In;
  logic [31:0] Val_Rm_In;
  logic [3:0]  Dest_In;
  logic        WB_EN_In;
  logic        MEM_R_EN_In;
  logic        MEM_W_EN_In;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] PC_Out;
  logic [31:0] ALU_Res_Out;
  logic [31:0] Val_Rm_Out;
  logic [3:0]  Dest_Out;
  logic        WB_EN_Out;
  logic        MEM_R_EN_Out;
  logic        MEM_W_EN_Out;
`ifdef EX_MEM_STAGE_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  int    checks   = 0;
  int    failures = 0;
  bit    mon_en   = 1'b0;
  item_t sb[$];

  always #5 CLK = ~CLK;

  ex_mem_stage_reg #(.PC_W(32), .DATA_W(32), .DEST_W(4)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .PC_In        (PC_In),
    .ALU_Res_In   (ALU_Res_In),
    .Val_Rm_In    (Val_Rm_In),
    .Dest_In      (Dest_In),
    .WB_EN_In     (WB_EN_In),
    .MEM_R_EN_In  (MEM_R_EN_In),
    .MEM_W_EN_In  (MEM_W_EN_In),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .PC_Out       (PC_Out),
    .ALU_Res_Out  (ALU_Res_Out),
    .Val_Rm_Out   (Val_Rm_Out),
    .Dest_Out     (Dest_Out),
    .WB_EN_Out    (WB_EN_Out),
    .MEM_R_EN_Out (MEM_R_EN_Out),
    .MEM_W_EN_Out (MEM_W_EN_Out)
`ifdef EX_MEM_STAGE_STATS_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus. Inputs change 1 time unit after the rising edge;
  // the handshake is checked on the falling edge; the scoreboard is updated
  // at the rising edge where the stage actually takes the bundle.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                     input logic [31:0] rm, input logic [3:0] dest,
                     input logic wb, input logic mr, input logic mw,
                     input logic ordy, input logic fl, input logic rst,
                     input logic exp_ov, input logic exp_ir);
    logic  rdy;
    item_t it;
    in_valid    = v;
    PC_In       = pc;
    ALU_Res_In  = alu;
    Val_Rm_In   = rm;
    Dest_In     = dest;
    WB_EN_In    = wb;
    MEM_R_EN_In = mr;
    MEM_W_EN_In = mw;
    out_ready   = ordy;
    flush       = fl;
    RST         = rst;
    @(negedge CLK);
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    check("in_ready", 32'(in_ready), 32'(exp_ir));
    rdy = in_ready;
    @(posedge CLK);
    if (rst || fl) begin
      sb.delete();
    end else if (v && rdy) begin
      it = '{pc: pc, alu: alu, rm: rm, dest: dest, wb: wb, mr: mr, mw: mw};
      sb.push_back(it);
    end
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_PC_Out"},      PC_Out,               32'h0);
    check({tag, "_ALU_Res_Out"}, ALU_Res_Out,          32'h0);
    check({tag, "_Val_Rm_Out"},  Val_Rm_Out,           32'h0);
    check({tag, "_Dest_Out"},    32'(Dest_Out),        32'h0);
    check({tag, "_WB_EN_Out"},   32'(WB_EN_Out),       32'h0);
    check({tag, "_MEM_R_EN"},    32'(MEM_R_EN_Out),    32'h0);
    check({tag, "_MEM_W_EN"},    32'(MEM_W_EN_Out),    32'h0);
    check({tag, "_out_valid"},   32'(out_valid),       32'h0);
    check({tag, "_in_ready"},    32'(in_ready),        32'h1);
  endtask

  // Monitor: completed transfers are compared against the scoreboard head.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got PC 0x%0h expected no transfer at %0t", PC_Out, $time);
        end else begin
          item_t e;
          e = sb.pop_front();
          check("mon_PC",     PC_Out,             e.pc);
          check("mon_ALU",    ALU_Res_Out,        e.alu);
          check("mon_Rm",     Val_Rm_Out,         e.rm);
          check("mon_Dest",   32'(Dest_Out),      32'(e.dest));
          check("mon_WB_EN",  32'(WB_EN_Out),     32'(e.wb));
          check("mon_MEM_R",  32'(MEM_R_EN_Out),  32'(e.mr));
          check("mon_MEM_W",  32'(MEM_W_EN_Out),  32'(e.mw));
        end
      end else if (out_valid === 1'b0) begin
        check("bubble_WB_EN",  32'(WB_EN_Out),    32'h0);
        check("bubble_MEM_R",  32'(MEM_R_EN_Out), 32'h0);
        check("bubble_MEM_W",  32'(MEM_W_EN_Out), 32'h0);
      end
    end
  end

  initial begin
    RST = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    PC_In = '0; ALU_Res_In = '0; Val_Rm_In = '0; Dest_In = '0;
    WB_EN_In = 1'b0; MEM_R_EN_In = 1'b0; MEM_W_EN_In = 1'b0;

    // Reset for two cycles, then idle state.
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    mon_en = 1'b1;
    @(negedge CLK);
    check_outputs_zero("reset");
`ifdef EX_MEM_STAGE_STATS_EN
    check("reset_stall_cnt", stall_cnt, 32'h0);
    check("reset_flush_cnt", flush_cnt, 32'h0);
`endif
    @(posedge CLK);
    #1;

    //  v  pc          alu         rm          dst wb mr mw  ordy fl rst ov ir
    // Streaming, one bundle per cycle, drain+accept on a full main entry.
    cyc(1, 32'h0000, 32'h10, 32'hA0, 4'd1, 1, 0, 0,  1, 0, 0,  0, 1);
    cyc(1, 32'h0004, 32'h20, 32'hA1, 4'd2, 1, 1, 0,  1, 0, 0,  1, 1);
    cyc(1, 32'h0008, 32'h30, 32'hA2, 4'd3, 0, 0, 1,  1, 0, 0,  1, 1);
    cyc(0, 32'h0000, 32'h00, 32'h00, 4'd0, 0, 0, 0,  1, 0, 0,  1, 1);
    cyc(0, 32'h0000, 32'h00, 32'h00, 4'd0, 0, 0, 0,  1, 0, 0,  0, 1);

    // Backpressure: A to main, B to skid, C ignored while full.
    cyc(1, 32'h0100, 32'h11, 32'hB0, 4'd3, 1, 0, 0,  0, 0, 0,  0, 1);
    cyc(1, 32'h0104, 32'h22, 32'hB1, 4'd5, 1, 0, 0,  0, 0, 0,  1, 1);
    cyc(1, 32'h0108, 32'h33, 32'hB2, 4'd6, 1, 0, 0,  0, 0, 0,  1, 0);
    check("bp_held_PC", PC_Out, 32'h0100);
    check("bp_held_Dest", 32'(Dest_Out), 32'd3);
    cyc(0, 32'h0000, 32'h00, 32'h00, 4'd0, 0, 0, 0,  1, 0, 0,  1, 0);
    cyc(0, 32'h0000, 32'h00, 32'h00, 4'd0, 0, 0, 0,  1, 0, 0,  1, 1);
    cyc(0, 32'h0000, 32'h00, 32'h00, 4'd0, 0, 0, 0,  1, 0, 0,  0, 1);

    // Bubble gating: store bundle drains, then the bubble must read zero.
    cyc(1, 32'h0200, 32'h44, 32'hC0, 4'd7, 1, 0, 1,  0, 0, 0,  0, 1);
    cyc(0, 32'h0000, 32'h00, 32'h00, 4'd0, 0, 0, 0,  1, 0, 0,  1, 1);
    cyc(0, 32'h0000, 32'h00, 32'h00, 4'd0, 0, 0, 0,  1, 0, 0,  0, 1);
    check("bubble_data_hold_PC", PC_Out, 32'h0200);

    // Flush with both entries full and in_valid high.
    cyc(1, 32'h0300, 32'h55, 32'hD0, 4'd8, 1, 1, 0,  0, 0, 0,  0, 1);
    cyc(1, 32'h0304, 32'h66, 32'hD1, 4'd9, 0, 0, 1,  0, 0, 0,  1, 1);
    cyc(1, 32'h0308, 32'h77, 32'hD2, 4'd10, 1, 0, 0, 0, 1, 0,  1, 0);
`ifdef EX_MEM_STAGE_STATS_EN
    check("flush_cnt_two", flush_cnt, 32'd2);
`endif
    cyc(0, 32'h0000, 32'h00, 32'h00, 4'd0, 0, 0, 0,  1, 0, 0,  0, 1);
    // Flush on an empty stage: the input taken that cycle is discarded.
    cyc(1, 32'h0400, 32'h88, 32'hE0, 4'd11, 1, 0, 1, 0, 1, 0,  0, 1);
    cyc(0, 32'h0000, 32'h00, 32'h00, 4'd0, 0, 0, 0,  1, 0, 0,  0, 1);
`ifdef EX_MEM_STAGE_STATS_EN
    check("flush_cnt_empty", flush_cnt, 32'd2);
`endif

    // Reset in the middle of backpressure with the skid entry full.
    cyc(1, 32'h0500, 32'h99, 32'hF0, 4'd12, 1, 0, 0, 0, 0, 0,  0, 1);
    cyc(1, 32'h0504, 32'hAA, 32'hF1, 4'd13, 0, 1, 0, 0, 0, 0,  1, 1);
    cyc(0, 32'h0000, 32'h00, 32'h00, 4'd0, 0, 0, 0,  0, 0, 0,  1, 0);
    cyc(0, 32'h0000, 32'h00, 32'h00, 4'd0, 0, 0, 0,  0, 0, 1,  1, 0);
    cyc(0, 32'h0000, 32'h00, 32'h00, 4'd0, 0, 0, 0,  0, 0, 0,  0, 1);
    check_outputs_zero("midreset");
`ifdef EX_MEM_STAGE_STATS_EN
    check("midreset_stall_cnt", stall_cnt, 32'h0);
    check("midreset_flush_cnt", flush_cnt, 32'h0);
`endif

    // The stage must work normally again after reset.
    cyc(1, 32'h0600, 32'hBB, 32'h12, 4'd14, 1, 1, 1, 1, 0, 0,  0, 1);
    cyc(0, 32'h0000, 32'h00, 32'h00, 4'd0, 0, 0, 0,  1, 0, 0,  1, 1);
    cyc(0, 32'h0000, 32'h00, 32'h00, 4'd0, 0, 0, 0,  1, 0, 0,  0, 1);

    check("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage_reg.md
Name: ex_mem_stage_reg

Overview:
- Parametrised EX→MEM pipeline register for the ARM-style core.
- Supersedes the PC-only EX register: carries the full EX result bundle (PC, ALU result, Rm value, destination, WB/MEM control bits).
- Adds a valid/ready handshake with a two-entry skid buffer, synchronous flush and bubble-safe control outputs.
- Sits between the EX stage and the MEM stage; the MEM stage back-pressures through out_ready.

Parameters:
- PC_W, 32, PC field width
- DATA_W, 32, ALU result and Rm value width
- DEST_W, 4, destination register index width

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset; synchronous, active-high
- flush  in  1  discard all held and incoming entries
- in_valid  in  1  EX bundle valid
- in_ready  out  1  stage can accept this cycle
- PC_In  in  PC_W  instruction PC
- ALU_Res_In  in  DATA_W  ALU result / memory address
- Val_Rm_In  in  DATA_W  store data
- Dest_In  in  DEST_W  writeback register
- WB_EN_In, MEM_R_EN_In, MEM_W_EN_In  in  1 each  control bits
- out_valid  out  1  output bundle valid
- out_ready  in  1  MEM stage accepts
- PC_Out, ALU_Res_Out, Val_Rm_Out, Dest_Out  out  widths as inputs  registered bundle
- WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out  out  1 each  control bits, gated by out_valid

Behaviour:
- Storage: main entry (drives outputs) and skid entry, each with its own valid bit.
- in_ready = ~skid_valid. Combinational from a register only; never depends on in_valid or out_ready.
- Accept occurs when in_valid & in_ready. Drain occurs when out_valid & out_ready.
- Main entry loads when main is empty or draining:
  - skid holds data → main takes the skid entry and skid clears;
  - else an accepted input goes to main;
  - else main_valid clears.
- Accept while main is valid and not draining → input goes to skid.
- Ordering is strict FIFO; no entry is dropped or duplicated.
- Latency: accept at cycle N → out_valid at N+1 when the stage was empty.
- Full throughput: with out_ready held high, one bundle per cycle and skid stays empty.
- Full (skid_valid=1): in_ready=0. Input is ignored regardless of in_valid.
- Simultaneous drain + accept while main is full, skid empty: main reloads from input; skid is untouched.
- Control gating: WB_EN_Out, MEM_R_EN_Out and MEM_W_EN_Out are the stored bit AND out_valid, so a bubble never writes memory or the register file.
- Data outputs hold their last value while invalid.
- Flush: on the next edge main_valid and skid_valid clear. Flush overrides accept and reload; any input accepted in the flush cycle is discarded. Data registers may load but are don't-care.
- Reset: all valids 0 and every output 0; in_ready=1 from the first cycle after reset. Reset asserted mid-transfer discards both entries. Reset overrides flush.

Optional Feature:
- Macro: EX_MEM_STAGE_STATS_EN.
- Defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments each cycle out_valid & ~out_ready.
  - flush_cnt increments by the number of valid entries discarded by a flush (0–2).
  - Both clear on RST and wrap modulo 2^32.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset then idle: RST high 2 cycles → all outputs 0, out_valid=0, in_ready=1.
- Streaming: out_ready=1, send PC 0x0,0x4,0x8 with ALU_Res 0x10,0x20,0x30 on consecutive cycles → same sequence on outputs one cycle later, back-to-back, in_ready stays 1.
- Backpressure: out_ready=0, send A(Dest=3) and B(Dest=5) → A held on outputs, in_ready=0 after B. Raise out_ready → A then B, in_ready returns 1.
- Bubble gating: load WB_EN=1, MEM_W_EN=1, then drain with in_valid=0 → WB_EN_Out=MEM_W_EN_Out=0 while out_valid=0.
- Flush with both entries full plus in_valid=1 → next cycle out_valid=0, in_ready=1, no output of the flushed entries. With macro defined, flush_cnt=2.
- Reset mid-backpressure: skid full, assert RST → next cycle all valids 0, outputs 0. With macro defined, stall_cnt=0.
